// File: rtl/param_unlock_mech.sv
// -----------------------------------------------------------------------------
// param_unlock_mech
// Serial code-lock. Frames of CODE_LEN bits arrive MSB first on ser_data,
// qualified by ser_val. Gaps between bits are allowed. The whole frame is
// compared against a programmable code register. A match sets the unlocked
// flag. MAX_FAIL consecutive mismatches force a LOCKOUT_CYCLES-long lockout.
// While unlocked, a new code can be programmed serially in the same way.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   ser_val      serial bit valid
//   ser_data     serial bit value
//   abort        discard the partial frame or programming sequence
//   prog_en      enter programming mode (IDLE and unlocked only)
//   relock       clear the unlocked flag
//   output_val   strobe in the cycle the last frame bit is accepted
//   output_data  1 = frame matched the code (valid with output_val)
//   unlocked     unlock status
//   locked_out   high while in lockout
//   fail_cnt     consecutive failed frames
//   prog_done    strobe in the cycle the last programming bit is accepted
// -----------------------------------------------------------------------------
module param_unlock_mech #(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = CODE_LEN'(4'b1011),
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ser_val,
    input  logic                            ser_data,
    input  logic                            abort,
    input  logic                            prog_en,
    input  logic                            relock,
    output logic                            output_val,
    output logic                            output_data,
    output logic                            unlocked,
    output logic                            locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic                            prog_done
);

    localparam int CW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [CW-1:0] LAST_IDX  = CW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PROG    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_e;

    state_e              state_q,    state_d;
    logic [CW-1:0]       cnt_q,      cnt_d;
    // Only the bits preceding the final one need storing: the final bit is
    // taken straight from ser_data when the frame completes.
    logic [CODE_LEN-2:0] shift_q,    shift_d;
    logic [TW-1:0]       timer_q,    timer_d;
    logic [FW-1:0]       fail_q,     fail_d;
    logic                unlocked_q, unlocked_d;
    logic [CODE_LEN-1:0] code_q,     code_d;

    logic [CODE_LEN-1:0] frame_s;
    logic                last_s;
    logic                match_s;
    logic [FW-1:0]       fail_inc_s;

    assign frame_s    = {shift_q, ser_data};
    assign last_s     = ser_val && (cnt_q == LAST_IDX);
    assign match_s    = (frame_s == code_q);
    assign fail_inc_s = fail_q + FW'(1);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CW{1'b0}};
            shift_q    <= {(CODE_LEN-1){1'b0}};
            timer_q    <= {TW{1'b0}};
            fail_q     <= {FW{1'b0}};
            unlocked_q <= 1'b0;
            code_q     <= CODE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            unlocked_q <= unlocked_d;
            code_q     <= code_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        timer_d    = timer_q;
        fail_d     = fail_q;
        code_d     = code_q;
        // relock overrides any unlock earned in the same cycle
        unlocked_d = relock ? 1'b0 : unlocked_q;
        case (state_q)
            S_IDLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ser_val) begin
                    shift_d = frame_s[CODE_LEN-2:0];
                    cnt_d   = CW'(1);
                    state_d = S_COLLECT;
                end else if (prog_en && unlocked_q && !relock) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_PROG;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_IDLE;
                end else if (last_s) begin
                    cnt_d   = {CW{1'b0}};
                    shift_d = frame_s[CODE_LEN-2:0];
                    if (match_s) begin
                        unlocked_d = !relock;
                        fail_d     = {FW{1'b0}};
                        state_d    = S_IDLE;
                    end else if (fail_inc_s == FAIL_MAX) begin
                        fail_d  = fail_inc_s;
                        timer_d = LOCK_LOAD;
                        state_d = S_LOCKOUT;
                    end else begin
                        fail_d  = fail_inc_s;
                        state_d = S_IDLE;
                    end
                end else if (ser_val) begin
                    shift_d = frame_s[CODE_LEN-2:0];
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_PROG: begin
                if (abort || relock) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_IDLE;
                end else if (last_s) begin
                    code_d  = frame_s;
                    shift_d = frame_s[CODE_LEN-2:0];
                    cnt_d   = {CW{1'b0}};
                    state_d = S_IDLE;
                end else if (ser_val) begin
                    shift_d = frame_s[CODE_LEN-2:0];
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    state_d = S_PROG;
                end
            end
            S_LOCKOUT: begin
                // Timer loaded with LOCKOUT_CYCLES-1 so the state lasts exactly
                // LOCKOUT_CYCLES cycles including the exit cycle.
                if (timer_q == {TW{1'b0}}) begin
                    fail_d  = {FW{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; Mealy strobes and status are forced low during reset.
    always_comb begin
        output_val  = 1'b0;
        output_data = 1'b0;
        prog_done   = 1'b0;
        unlocked    = 1'b0;
        locked_out  = 1'b0;
        fail_cnt    = {FW{1'b0}};
        if (rst) begin
            output_val  = 1'b0;
            prog_done   = 1'b0;
        end else begin
            if ((state_q == S_COLLECT) && !abort && last_s) begin
                output_val  = 1'b1;
                output_data = match_s;
            end else begin
                output_val  = 1'b0;
                output_data = 1'b0;
            end
            prog_done  = (state_q == S_PROG) && !abort && !relock && last_s;
            unlocked   = unlocked_q;
            locked_out = (state_q == S_LOCKOUT);
            fail_cnt   = fail_q;
        end
    end

endmodule

// File: tb/tb_param_unlock_mech.sv
// Testbench for param_unlock_mech: instance A uses default parameters,
// instance B uses CODE_LEN=8, CODE=8'hA5, MAX_FAIL=1, LOCKOUT_CYCLES=5.
// Both share the same input stimulus.
module tb_param_unlock_mech;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic ser_val = 1'b0, ser_data = 1'b0, abort = 1'b0, prog_en = 1'b0, relock = 1'b0;

    logic       ov_a, od_a, unl_a, lo_a, pd_a;
    logic [1:0] fc_a;
    logic       ov_b, od_b, unl_b, lo_b, pd_b;
    logic [0:0] fc_b;

    int tests = 0;
    int fails = 0;

    // captured outputs, index 0 = A, 1 = B
    logic c_ov[2], c_od[2], c_pd[2], c_unl[2], c_lo[2];
    int   c_fc[2];

    // reference model state
    int          len_p[2]   = '{4, 8};
    logic [31:0] code_p[2]  = '{32'hB, 32'hA5};
    int          maxf_p[2]  = '{3, 1};
    int          lockc_p[2] = '{16, 5};
    logic [31:0] m_code[2];
    logic [31:0] m_frame[2];
    int          m_nbits[2];
    bit          m_busy[2];
    bit          m_prog[2];
    int          m_lock[2];
    int          m_fail[2];
    bit          m_unl[2];

    param_unlock_mech dut_a (
        .clk(clk), .rst(rst), .ser_val(ser_val), .ser_data(ser_data),
        .abort(abort), .prog_en(prog_en), .relock(relock),
        .output_val(ov_a), .output_data(od_a), .unlocked(unl_a),
        .locked_out(lo_a), .fail_cnt(fc_a), .prog_done(pd_a)
    );

    param_unlock_mech #(
        .CODE_LEN(8), .CODE(8'hA5), .MAX_FAIL(1), .LOCKOUT_CYCLES(5)
    ) dut_b (
        .clk(clk), .rst(rst), .ser_val(ser_val), .ser_data(ser_data),
        .abort(abort), .prog_en(prog_en), .relock(relock),
        .output_val(ov_b), .output_data(od_b), .unlocked(unl_b),
        .locked_out(lo_b), .fail_cnt(fc_b), .prog_done(pd_b)
    );

    // Drive one cycle of inputs at the falling edge, then capture outputs.
    task automatic step(input logic v, input logic d, input logic ab,
                        input logic pe, input logic rl, input logic r);
        @(negedge clk);
        ser_val = v; ser_data = d; abort = ab; prog_en = pe; relock = rl; rst = r;
        #1;
        c_ov[0] = ov_a; c_od[0] = od_a; c_pd[0] = pd_a; c_unl[0] = unl_a; c_lo[0] = lo_a; c_fc[0] = int'(fc_a);
        c_ov[1] = ov_b; c_od[1] = od_b; c_pd[1] = pd_b; c_unl[1] = unl_b; c_lo[1] = lo_b; c_fc[1] = int'(fc_b);
    endtask

    task automatic bitstep(input logic b);
        step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Send a 4-bit frame to instance A (MSB first), leaving the final-bit capture.
    task automatic send4(input logic [3:0] f);
        for (int i = 3; i >= 0; i--) bitstep(f[i]);
    endtask

    // Behavioural reference: one clock of the lock described in frame terms.
    task automatic model_step(input int k, input logic v, input logic d, input logic ab,
                              input logic pe, input logic rl, input logic r,
                              output logic eov, output logic eod, output logic epd);
        logic [31:0] f;
        logic [31:0] mask;
        bit          nu;
        eov = 1'b0; eod = 1'b0; epd = 1'b0;
        mask = (len_p[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << len_p[k]) - 32'h1);
        if (r) begin
            m_code[k] = code_p[k]; m_frame[k] = 32'h0; m_nbits[k] = 0;
            m_busy[k] = 1'b0; m_prog[k] = 1'b0; m_lock[k] = 0; m_fail[k] = 0; m_unl[k] = 1'b0;
        end else begin
            nu = m_unl[k];
            if (m_lock[k] > 0) begin
                m_lock[k]--;
                if (m_lock[k] == 0) m_fail[k] = 0;
            end else if (m_busy[k]) begin
                if (ab || (m_prog[k] && rl)) begin
                    m_busy[k] = 1'b0; m_prog[k] = 1'b0; m_nbits[k] = 0;
                end else if (v) begin
                    m_frame[k] = {m_frame[k][30:0], d};
                    m_nbits[k]++;
                    if (m_nbits[k] == len_p[k]) begin
                        f = m_frame[k] & mask;
                        if (m_prog[k]) begin
                            epd = 1'b1;
                            m_code[k] = f;
                        end else begin
                            eov = 1'b1;
                            eod = (f == m_code[k]);
                            if (eod) begin
                                nu = 1'b1; m_fail[k] = 0;
                            end else begin
                                m_fail[k]++;
                                if (m_fail[k] == maxf_p[k]) m_lock[k] = lockc_p[k];
                            end
                        end
                        m_busy[k] = 1'b0; m_prog[k] = 1'b0; m_nbits[k] = 0;
                    end
                end
            end else begin
                if (!ab && v) begin
                    m_busy[k] = 1'b1; m_prog[k] = 1'b0; m_frame[k] = {31'h0, d}; m_nbits[k] = 1;
                end else if (!ab && pe && m_unl[k] && !rl) begin
                    m_busy[k] = 1'b1; m_prog[k] = 1'b1; m_frame[k] = 32'h0; m_nbits[k] = 0;
                end
            end
            if (rl) nu = 1'b0;
            m_unl[k] = nu;
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tests++;
        if ({c_ov[0], c_od[0], c_pd[0], c_unl[0], c_lo[0]} !== 5'b0 || c_fc[0] != 0) begin
            fails++; $display("FAIL reset_outputs got=%b%b%b%b%b fc=%0d exp=00000 fc=0",
                c_ov[0], c_od[0], c_pd[0], c_unl[0], c_lo[0], c_fc[0]);
        end
        idle();
        tests++;
        if ({c_unl[0], c_lo[0]} !== 2'b00 || c_fc[0] != 0) begin
            fails++; $display("FAIL reset_state got unl=%b lo=%b fc=%0d exp 0 0 0", c_unl[0], c_lo[0], c_fc[0]);
        end
    endtask

    task automatic test_unlock();
        logic [3:0] pat = 4'b1011;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bitstep(pat[3-i]);
            tests++;
            if (c_ov[0] !== logic'(i == 3)) begin
                fails++; $display("FAIL unlock_ov bit%0d got=%b exp=%b", i, c_ov[0], logic'(i == 3));
            end
        end
        tests++;
        if (c_od[0] !== 1'b1) begin fails++; $display("FAIL unlock_od got=%b exp=1", c_od[0]); end
        idle();
        tests++;
        if (c_unl[0] !== 1'b1 || c_fc[0] != 0) begin
            fails++; $display("FAIL unlock_state got unl=%b fc=%0d exp unl=1 fc=0", c_unl[0], c_fc[0]);
        end
    endtask

    task automatic test_lockout();
        logic [3:0] pat = 4'b1011;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            send4(4'b1111);
            tests++;
            if ({c_ov[0], c_od[0]} !== 2'b10) begin
                fails++; $display("FAIL lockout_frame%0d got ov=%b od=%b exp ov=1 od=0", f, c_ov[0], c_od[0]);
            end
            if (f < 2) begin
                idle();
                tests++;
                if (c_fc[0] != f + 1 || c_lo[0] !== 1'b0) begin
                    fails++; $display("FAIL lockout_fc%0d got fc=%0d lo=%b exp fc=%0d lo=0", f, c_fc[0], c_lo[0], f + 1);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            bitstep(pat[3 - (i % 4)]);
            tests++;
            if (c_lo[0] !== 1'b1 || c_ov[0] !== 1'b0) begin
                fails++; $display("FAIL lockout_cycle%0d got lo=%b ov=%b exp lo=1 ov=0", i, c_lo[0], c_ov[0]);
            end
            if (i == 0) begin
                tests++;
                if (c_fc[0] != 3) begin fails++; $display("FAIL lockout_fc_max got=%0d exp=3", c_fc[0]); end
            end
        end
        idle();
        tests++;
        if (c_lo[0] !== 1'b0 || c_fc[0] != 0) begin
            fails++; $display("FAIL lockout_exit got lo=%b fc=%0d exp lo=0 fc=0", c_lo[0], c_fc[0]);
        end
    endtask

    task automatic test_program();
        logic [3:0] np = 4'b0110;
        do_reset();
        send4(4'b1011);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bitstep(np[3-i]);
            tests++;
            if (c_pd[0] !== logic'(i == 3) || c_ov[0] !== 1'b0) begin
                fails++; $display("FAIL prog_bit%0d got pd=%b ov=%b exp pd=%b ov=0", i, c_pd[0], c_ov[0], logic'(i == 3));
            end
        end
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        tests++;
        if (c_unl[0] !== 1'b0) begin fails++; $display("FAIL prog_relock got unl=%b exp=0", c_unl[0]); end
        send4(4'b1011);
        tests++;
        if ({c_ov[0], c_od[0]} !== 2'b10) begin
            fails++; $display("FAIL prog_oldcode got ov=%b od=%b exp ov=1 od=0", c_ov[0], c_od[0]);
        end
        send4(4'b0110);
        tests++;
        if ({c_ov[0], c_od[0]} !== 2'b11) begin
            fails++; $display("FAIL prog_newcode got ov=%b od=%b exp ov=1 od=1", c_ov[0], c_od[0]);
        end
        idle();
        tests++;
        if (c_unl[0] !== 1'b1) begin fails++; $display("FAIL prog_unlock got unl=%b exp=1", c_unl[0]); end
    endtask

    task automatic test_abort_gaps();
        logic [3:0] pat = 4'b1011;
        int         nov = 0;
        do_reset();
        send4(4'b1111);
        idle();
        // abort together with what would be the final bit
        bitstep(1'b1); bitstep(1'b0); bitstep(1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++;
        if (c_ov[0] !== 1'b0) begin fails++; $display("FAIL abort_final got ov=%b exp=0", c_ov[0]); end
        bitstep(1'b1); bitstep(1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        tests++;
        if (c_fc[0] != 1 || c_ov[0] !== 1'b0) begin
            fails++; $display("FAIL abort_fc got fc=%0d ov=%b exp fc=1 ov=0", c_fc[0], c_ov[0]);
        end
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 3; g++) begin
                idle();
                if (c_ov[0] === 1'b1) nov++;
            end
            bitstep(pat[3-i]);
            if (c_ov[0] === 1'b1) nov++;
        end
        tests++;
        if (c_od[0] !== 1'b1 || nov != 1) begin
            fails++; $display("FAIL gap_frame got od=%b strobes=%0d exp od=1 strobes=1", c_od[0], nov);
        end
        idle();
        tests++;
        if (c_unl[0] !== 1'b1 || c_fc[0] != 0) begin
            fails++; $display("FAIL gap_state got unl=%b fc=%0d exp unl=1 fc=0", c_unl[0], c_fc[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send4(4'b1011);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send4(4'b0110);
        idle();
        send4(4'b1111);
        bitstep(1'b0); bitstep(1'b1); bitstep(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({c_ov[0], c_od[0], c_unl[0], c_lo[0]} !== 4'b0 || c_fc[0] != 0) begin
            fails++; $display("FAIL rst_gate got ov=%b od=%b unl=%b lo=%b fc=%0d exp all 0",
                c_ov[0], c_od[0], c_unl[0], c_lo[0], c_fc[0]);
        end
        idle();
        tests++;
        if (c_unl[0] !== 1'b0 || c_fc[0] != 0) begin
            fails++; $display("FAIL rst_mid_state got unl=%b fc=%0d exp 0 0", c_unl[0], c_fc[0]);
        end
        send4(4'b0110);
        tests++;
        if ({c_ov[0], c_od[0]} !== 2'b10) begin
            fails++; $display("FAIL rst_code_revert got ov=%b od=%b exp ov=1 od=0", c_ov[0], c_od[0]);
        end
        send4(4'b1111);
        send4(4'b1111);
        for (int i = 0; i < 5; i++) idle();
        tests++;
        if (c_lo[0] !== 1'b1) begin fails++; $display("FAIL rst_pre_lock got lo=%b exp=1", c_lo[0]); end
        do_reset();
        idle();
        tests++;
        if (c_lo[0] !== 1'b0 || c_fc[0] != 0 || c_unl[0] !== 1'b0) begin
            fails++; $display("FAIL rst_lock_state got lo=%b fc=%0d unl=%b exp 0 0 0", c_lo[0], c_fc[0], c_unl[0]);
        end
        send4(4'b1011);
        tests++;
        if ({c_ov[0], c_od[0]} !== 2'b11) begin
            fails++; $display("FAIL rst_unlock got ov=%b od=%b exp 1 1", c_ov[0], c_od[0]);
        end
        idle();
        tests++;
        if (c_unl[0] !== 1'b1) begin fails++; $display("FAIL rst_unlock_flag got=%b exp=1", c_unl[0]); end
    endtask

    task automatic test_param_b();
        logic [7:0] wrong;
        logic [7:0] good = 8'hA5;
        wrong = 8'($urandom_range(0, 255));
        if (wrong == good) wrong = 8'h5A;
        do_reset();
        for (int i = 7; i >= 0; i--) bitstep(wrong[i]);
        tests++;
        if ({c_ov[1], c_od[1]} !== 2'b10) begin
            fails++; $display("FAIL b_wrong got ov=%b od=%b exp 1 0", c_ov[1], c_od[1]);
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            tests++;
            if (c_lo[1] !== 1'b1) begin fails++; $display("FAIL b_lock%0d got lo=%b exp=1", i, c_lo[1]); end
        end
        idle();
        tests++;
        if (c_lo[1] !== 1'b0 || c_fc[1] != 0) begin
            fails++; $display("FAIL b_exit got lo=%b fc=%0d exp 0 0", c_lo[1], c_fc[1]);
        end
        for (int i = 7; i >= 0; i--) bitstep(good[i]);
        tests++;
        if ({c_ov[1], c_od[1]} !== 2'b11) begin
            fails++; $display("FAIL b_good got ov=%b od=%b exp 1 1", c_ov[1], c_od[1]);
        end
        idle();
        tests++;
        if (c_unl[1] !== 1'b1) begin fails++; $display("FAIL b_unlock got=%b exp=1", c_unl[1]); end
    endtask

    task automatic test_random();
        logic v, d, ab, pe, rl, r;
        logic eov, eod, epd, eunl, elo;
        int   efc;
        for (int n = 0; n < 4000; n++) begin
            r  = (n == 0) || ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 2) != 0);
            d  = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 39) == 0);
            pe = ($urandom_range(0, 7) == 0);
            rl = ($urandom_range(0, 59) == 0);
            step(v, d, ab, pe, rl, r);
            for (int k = 0; k < 2; k++) begin
                eunl = !r && m_unl[k];
                elo  = !r && (m_lock[k] > 0);
                efc  = r ? 0 : m_fail[k];
                model_step(k, v, d, ab, pe, rl, r, eov, eod, epd);
                tests++;
                if ({c_ov[k], c_od[k], c_pd[k], c_unl[k], c_lo[k]} !== {eov, eod, epd, eunl, elo}) begin
                    fails++; $display("FAIL rand_flags dut%0d cyc%0d got=%b%b%b%b%b exp=%b%b%b%b%b", k, n,
                        c_ov[k], c_od[k], c_pd[k], c_unl[k], c_lo[k], eov, eod, epd, eunl, elo);
                end
                tests++;
                if (c_fc[k] != efc) begin
                    fails++; $display("FAIL rand_fail_cnt dut%0d cyc%0d got=%0d exp=%0d", k, n, c_fc[k], efc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_program();
        test_abort_gaps();
        test_reset_mid();
        test_param_b();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_unlock_mech.md
PARAM_UNLOCK_MECH -- requirements
Module: param_unlock_mech

Parameters
REQ-001 SHALL provide parameter CODE_LEN, default 4, number of serial bits per code frame (legal range 2..32).
REQ-002 SHALL provide parameter CODE, default 4'b1011 (width CODE_LEN), the reset unlock code; first bit received compares against MSB.
REQ-003 SHALL provide parameter MAX_FAIL, default 3, consecutive failed frames that trigger lockout (legal ≥1).
REQ-004 SHALL provide parameter LOCKOUT_CYCLES, default 16, lockout duration in clk cycles (legal ≥1).

Interface
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ser_val  in  1  serial bit valid, one bit per cycle when high.
REQ-008 ser_data  in  1  serial bit value.
REQ-009 abort  in  1  discard partial frame, return to IDLE.
REQ-010 prog_en  in  1  request code-programming mode; honoured only in IDLE with unlocked=1.
REQ-011 relock  in  1  clear unlocked flag.
REQ-012 output_val  out  1  Mealy result strobe, high in the cycle the final frame bit is accepted.
REQ-013 output_data  out  1  result, 1 = code match; meaningful only with output_val.
REQ-014 unlocked  out  1  registered unlock status.
REQ-015 locked_out  out  1  high while in LOCKOUT.
REQ-016 fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failed frames.
REQ-017 prog_done  out  1  Mealy strobe, high in the cycle the final programming bit is accepted.

Function
REQ-018 States SHALL be IDLE, COLLECT, PROG, LOCKOUT; bit counter counts 0..CODE_LEN-1; shift register width CODE_LEN.
REQ-019 Cycles with ser_val=0 SHALL hold state, counter and shift register (gaps between bits allowed, no timeout).
REQ-020 IDLE: ser_val=1 -> shift bit, counter=1, go COLLECT; prog_en=1 and unlocked=1 and ser_val=0 -> go PROG, counter=0; ser_val=1 takes priority over prog_en.
REQ-021 COLLECT: ser_val=1 with counter<CODE_LEN-1 -> shift, counter+1.
REQ-022 COLLECT final bit (ser_val=1, counter=CODE_LEN-1): output_val=1 combinationally, output_data = ({shift[CODE_LEN-2:0],ser_data} == code register); whole frame compared, no early reject on first wrong bit.
REQ-023 On match: unlocked<=1, fail_cnt<=0, go IDLE.
REQ-024 On mismatch: fail_cnt+1; if new value equals MAX_FAIL go LOCKOUT with timer loaded LOCKOUT_CYCLES-1, else go IDLE; unlocked unchanged.
REQ-025 LOCKOUT: locked_out=1; ser_val, prog_en, abort ignored; timer decrements each cycle; at timer=0 go IDLE, fail_cnt<=0; locked_out high for exactly LOCKOUT_CYCLES cycles.
REQ-026 PROG: accept CODE_LEN bits like COLLECT; on final bit prog_done=1 combinationally, code register <= new frame next edge, go IDLE; output_val stays 0 in PROG.
REQ-027 abort=1 in COLLECT or PROG SHALL go IDLE, clear counter, leave code register, fail_cnt and unlocked unchanged; abort wins over a simultaneous final bit (no output_val/prog_done that cycle).
REQ-028 relock=1 SHALL clear unlocked next edge in any state; relock concurrent with successful match leaves unlocked=0; relock in PROG also aborts programming.
REQ-029 output_val, output_data, prog_done SHALL be 0 whenever not explicitly driven above.
REQ-030 fail_cnt SHALL never exceed MAX_FAIL.

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE, counter=0, shift=0, timer=0, fail_cnt=0, unlocked=0, code register=CODE, in any state including mid-frame and LOCKOUT.
REQ-032 While rst=1 all outputs SHALL be 0 (Mealy strobes gated by rst).

Verification
REQ-033 Reset, bits 1,0,1,1 with ser_val -> 4th-bit cycle output_val=1,output_data=1; unlocked=1 next cycle; fail_cnt=0.
REQ-034 Bits 1,1,1,1 three times -> output_data=0 each, fail_cnt 1,2, then locked_out=1 for 16 cycles; 1,0,1,1 sent during lockout produces no output_val; fail_cnt=0 after exit.
REQ-035 Unlock, prog_en, bits 0,1,1,0 -> prog_done=1 on 4th bit; relock; 1,0,1,1 -> output_data=0; 0,1,1,0 -> output_data=1.
REQ-036 Bits 1,0 then abort, then 1,0,1,1 with ser_val gaps of 3 cycles -> no output after abort, single output_val with output_data=1 at the final bit, fail_cnt unchanged.
REQ-037 rst asserted mid-frame and mid-lockout after programming -> IDLE, locked_out=0, fail_cnt=0, unlocked=0; 1,0,1,1 then unlocks (code reverted to CODE).
REQ-038 Parameter sweep CODE_LEN=8, CODE=8'hA5, MAX_FAIL=1, LOCKOUT_CYCLES=5 -> single wrong frame enters lockout for 5 cycles; correct frame unlocks.
